// File: rtl/and_ctrl_pkg.sv
// Shared types and constants for the 8-way, 16-bit AND sequencing controller.
package and_ctrl_pkg;

  localparam int unsigned AND_WAYS  = 8;
  localparam int unsigned AND_WIDTH = 16;
  localparam int unsigned CNT_W     = 4;

  localparam logic [AND_WIDTH-1:0] AND_PAD = 16'hFFFF;

  typedef enum logic [1:0] {
    COLLECT,
    EVAL,
    HOLD
  } state_e;

  typedef logic [AND_WAYS-1:0][AND_WIDTH-1:0] slots_t;

  // A group closes on an explicit last word or when the final slot is being written.
  function automatic logic closes_group(input logic [CNT_W-1:0] cnt, input logic last);
    return last || (cnt == CNT_W'(AND_WAYS - 1));
  endfunction

endpackage

// File: rtl/and8way16.sv
// Combinational 8-way, 16-bit bitwise AND reducer built as a balanced three-level tree.
module and8way16
  import and_ctrl_pkg::*;
(
  input  slots_t                words,
  output logic [AND_WIDTH-1:0]  result
);

  logic [3:0][AND_WIDTH-1:0] lvl1;
  logic [1:0][AND_WIDTH-1:0] lvl2;

  always_comb begin
    lvl1 = '0;
    lvl2 = '0;
    for (int i = 0; i < 4; i++) begin
      lvl1[i] = words[2*i] & words[2*i+1];
    end
    for (int i = 0; i < 2; i++) begin
      lvl2[i] = lvl1[2*i] & lvl1[2*i+1];
    end
    result = lvl2[0] & lvl2[1];
  end

endmodule

// File: rtl/and8way16_seq.sv
// Gathers 1..8 words into a group, reduces them through and8way16 and returns the
// registered AND and word count over a valid/ready handshake.
module and8way16_seq
  import and_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AND_WIDTH-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AND_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]     out_count
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  slots_t               slot_q, slot_d;
  logic [AND_WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]     out_count_q, out_count_d;
  logic [AND_WIDTH-1:0] and_result;

  and8way16 u_and8way16 (
    .words  (slot_q),
    .result (and_result)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    slot_d      = slot_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;

    unique case (state_q)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          slot_d[cnt_q[2:0]] = in_data;
          cnt_d              = cnt_q + 1'b1;
          if (closes_group(cnt_q, in_last)) begin
            state_d = EVAL;
          end
        end
      end
      EVAL: begin
        // Registering here keeps the reduction tree off the output path.
        out_data_d  = and_result;
        out_count_d = cnt_q;
        state_d     = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          slot_d  = {AND_WAYS{AND_PAD}};
          cnt_d   = '0;
          state_d = COLLECT;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      slot_q      <= {AND_WAYS{AND_PAD}};
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_and8way16_seq.sv
// Scenario-driven bench for and8way16_seq with a scoreboard of expected group results.
module tb_and8way16_seq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_count;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  count;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  and8way16_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every completed handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got data=%h count=%0d, required no output",
                 out_data, out_count);
      end else begin
        mon_e = sb.pop_front();
        if (out_data !== mon_e.data || out_count !== mon_e.count) begin
          errors++;
          $display("FAIL scoreboard_result: got data=%h count=%0d, required data=%h count=%0d",
                   out_data, out_count, mon_e.data, mon_e.count);
        end
      end
    end
  end

  task automatic send_word(input logic [15:0] d, input logic last);
    bit done = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0 for 50 cycles, required 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready && !out_valid) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: in_ready/out_valid got %b/%b, required 1/0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    checks++;
    if (out_data !== 16'h0000) begin
      errors++; $display("FAIL reset_out_data: got %h, required 0000", out_data);
    end
    checks++;
    if (out_count !== 4'd0) begin
      errors++; $display("FAIL reset_out_count: got %0d, required 0", out_count);
    end
  endtask

  task automatic test_full_group();
    out_ready = 1'b1;
    sb.push_back('{data: 16'h0F0F, count: 4'd8});
    for (int i = 0; i < 8; i++) begin
      send_word((i == 5) ? 16'h0F0F : 16'hFFFF, 1'b0);
    end
    // Now in the cycle after the 8th accept: EVAL.
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_eval_cycle: in_ready/out_valid got %b/%b, required 0/0",
               in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0F0F || out_count !== 4'd8) begin
      errors++;
      $display("FAIL full_latency: got valid=%b data=%h count=%0d, required valid=1 data=0f0f count=8",
               out_valid, out_data, out_count);
    end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_release: in_ready/out_valid got %b/%b, required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_single_word();
    out_ready = 1'b1;
    sb.push_back('{data: 16'h1234, count: 4'd1});
    send_word(16'h1234, 1'b1);
    wait_idle();
  endtask

  task automatic test_short_group();
    out_ready = 1'b1;
    sb.push_back('{data: 16'h0500, count: 4'd3});
    send_word(16'hA5A5, 1'b0);
    send_word(16'hFFF0, 1'b0);
    send_word(16'h0F0F, 1'b1);
    wait_idle();
  endtask

  task automatic test_backpressure();
    bit seen = 0;
    out_ready = 1'b0;
    sb.push_back('{data: 16'h3030, count: 4'd2});
    send_word(16'h3C3C, 1'b0);
    send_word(16'hF0F0, 1'b1);
    in_valid = 1'b1;
    in_data  = 16'h0000;
    in_last  = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL bp_valid_timeout: out_valid got 0, required 1");
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 16'h3030 || out_count !== 4'd2)
      begin
        errors++;
        $display("FAIL bp_hold_%0d: got valid=%b ready=%b data=%h count=%0d, required 1/0/3030/2",
                 i, out_valid, in_ready, out_data, out_count);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    sb.push_back('{data: 16'h0000, count: 4'd2});
    send_word(16'h0000, 1'b0);
    send_word(16'hFFFF, 1'b1);
    wait_idle();
  endtask

  task automatic test_reset_mid_group();
    bit seen = 0;
    out_ready = 1'b1;
    send_word(16'hFFFF, 1'b0);
    send_word(16'h0000, 1'b0);
    send_word(16'h1234, 1'b0);
    send_word(16'hFFFF, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.push_back('{data: 16'h0F00, count: 4'd2});
    send_word(16'hFF00, 1'b0);
    send_word(16'h0FF0, 1'b1);
    wait_idle();

    // Reset while a result is pending in HOLD drops it.
    out_ready = 1'b0;
    send_word(16'hAAAA, 1'b1);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (!seen || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_in_hold: seen=%b valid=%b ready=%b data=%h, required 1/0/1/0000",
               seen, out_valid, in_ready, out_data);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int got   = 0;
    int rel[3];
    int exp_at[3];
    exp_at = '{4, 14, 17};
    rel    = '{0, 0, 0};
    out_ready = 1'b1;
    sb.push_back('{data: 16'h000F, count: 4'd2});
    sb.push_back('{data: 16'hFF00, count: 4'd8});
    sb.push_back('{data: 16'hABCD, count: 4'd1});
    fork
      begin
        send_word(16'h00FF, 1'b0);
        send_word(16'h0F0F, 1'b1);
        for (int i = 0; i < 8; i++) begin
          send_word(16'hFFFF ^ (16'h0001 << i), 1'b0);
        end
        send_word(16'hABCD, 1'b1);
      end
      begin
        for (int i = 0; i < 60 && got < 3; i++) begin
          @(negedge clk);
          if (first < 0 && in_valid && in_ready) first = cyc;
          if (out_valid && out_ready) begin
            rel[got] = cyc - first + 1;
            got++;
          end
        end
      end
    join
    checks++;
    if (got != 3) begin
      errors++; $display("FAIL b2b_result_count: got %0d, required 3", got);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rel[k] != exp_at[k]) begin
        errors++; $display("FAIL b2b_cycle_%0d: got %0d, required %0d", k, rel[k], exp_at[k]);
      end
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_full_group();
    test_single_word();
    test_short_group();
    test_backpressure();
    test_reset_mid_group();
    test_back_to_back();
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/and8way16_seq.md
# and8way16_seq

Sequencing controller that gathers a stream of 16-bit words into groups of 1–8 and reduces each group to a single bitwise AND. It holds the words in an 8-entry operand buffer and drives one instance of the combinational `and8way16` reducer. Unused slots are padded with all-ones. The registered result is returned over a valid/ready handshake. It sits between a word producer and any consumer needing the group AND, such as mask merging or flag reduction.

## Interface
- Parameters: none; width (16) and way count (8) are fixed by `and8way16`.
- `clk` in 1 — single clock; all state updates on rising edge.
- `reset` in 1 — synchronous, active-high.
- `in_valid` in 1 — producer offers `in_data`.
- `in_ready` out 1 — controller accepts a word this cycle.
- `in_data` in 16 — operand word.
- `in_last` in 1 — qualifies the accepted word as the last of its group.
- `out_valid` out 1 — `out_data` / `out_count` hold a completed result.
- `out_ready` in 1 — consumer takes the result.
- `out_data` out 16 — AND of all words in the group.
- `out_count` out 4 — number of words in the group, 1..8.

## Operation
- FSM states:
  - **COLLECT**: `in_ready`=1. An accept is `in_valid & in_ready`. Each accept writes `in_data` to slot `cnt` and increments `cnt`.
  - Leave COLLECT for EVAL when an accept has `in_last`=1, or when `cnt` reaches 8 with or without `in_last`.
  - **EVAL**: `in_ready`=0. Register the `and8way16` output into `out_data` and `cnt` into `out_count`. Go to HOLD unconditionally.
  - **HOLD**: `out_valid`=1, `in_ready`=0. On `out_ready`=1, go to COLLECT next cycle; all 8 slots reload to 16'hFFFF and `cnt` clears to 0.
- Padding: any slot not written in the current group reads 16'hFFFF, so `out_data` equals the AND of only the accepted words.
- An empty group cannot occur: `in_last` only acts on an accepted word.
- `in_last` on the 8th word and an automatic close at 8 give identical behaviour.
- `in_data` and `in_last` are ignored whenever `in_ready`=0.
- `out_data` and `out_count` change only in EVAL. They stay stable through HOLD regardless of `out_ready`.
- Reset values:
  - state = COLLECT, `cnt` = 0, all slots = 16'hFFFF.
  - `out_data` = 16'h0000, `out_count` = 0, `out_valid` = 0, `in_ready` = 1 on the first cycle after reset.
- Reset mid-group (in COLLECT, EVAL or HOLD): discard the partial group or pending result; no output is produced for it.

## Timing
- The EVAL stage exists to keep the `and8way16` tree off the output path. No combinational path runs from `in_*` to `out_*`.
- Latency: closing accept at edge N puts the FSM in EVAL during cycle N+1. `out_valid`=1 from cycle N+2.
- With `out_ready` held high, a group of n words occupies n+2 cycles: n in COLLECT, 1 in EVAL, 1 in HOLD. The next group's first word is accepted in cycle N+3.
- Backpressure: HOLD persists any number of cycles. `in_ready` stays low for the whole of EVAL and HOLD.
- `out_ready` outside HOLD has no effect.

## Structure
- Shared package `and_ctrl_pkg` contains:
  - State enum {COLLECT, EVAL, HOLD}.
  - `AND_WAYS`=8.
  - `AND_PAD`=16'hFFFF.
  - Count width 4.
- Exactly one sub-module: an `and8way16` instance fed directly from the 8 slot registers. Control, buffer and output registers stay in this module.

## Test plan
- **Full group**: 8 words, all 16'hFFFF except 16'h0F0F in slot 5, no `in_last` → auto-close. `out_data`=16'h0F0F, `out_count`=8, `out_valid` rises 2 cycles after the 8th accept.
- **Single word**: 16'h1234 with `in_last` → `out_data`=16'h1234, `out_count`=1. Confirms padding.
- **Short group**: 16'hA5A5, 16'hFFF0, 16'h0F0F (last) → `out_data`=16'h0500, `out_count`=3.
- **Backpressure**: hold `out_ready`=0 for 5 HOLD cycles while `in_valid`=1 with 16'h0000.
  - Outputs must stay stable and `in_ready`=0.
  - No word is consumed; after `out_ready`=1, 16'h0000 becomes word 0 of the next group.
- **Reset mid-group**: accept 4 words including 16'h0000, assert `reset` 1 cycle, then send 16'hFF00, 16'h0FF0 (last).
  - No output for the aborted group.
  - Result: `out_data`=16'h0F00, `out_count`=2.
- **Back-to-back**: continuous `in_valid`/`out_ready`=1, groups of sizes 2, 8, 1.
  - Results arrive at cycles 4, 14, 17 after the first accept.
  - AND values are correct with no carry-over between groups.
